preset_sender: RTL and testbench
================================

PRESET_SENDER -- requirements
Module: preset_sender

Interface
REQ-001 The block SHALL have one parameter: MIDI_CHANNEL, default 0, the 4-bit MIDI channel placed in the low nibble of transmitted status bytes.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-004 The block SHALL have port btn_index, input, 2 bits, footswitch event code: 0 = none, 1..3 = slot number.
REQ-005 The block SHALL have port save_mode, input, 1 bit, qualifies the btn_index event as save (1) or recall (0).
REQ-006 The block SHALL have port prog_valid, input, 1 bit, one-cycle strobe of a program number received on MIDI in.
REQ-007 The block SHALL have port prog_num, input, 7 bits, received program number, valid when prog_valid=1.
REQ-008 The block SHALL have port tx_data, output, 8 bits, byte offered to the MIDI UART transmitter.
REQ-009 The block SHALL have port tx_valid, output, 1 bit, tx_data is valid.
REQ-010 The block SHALL have port tx_ready, input, 1 bit, transmitter accepts tx_data this cycle.
REQ-011 The block SHALL have port active_slot, output, 2 bits, last saved or recalled slot (0 = none).
REQ-012 The block SHALL have port saved, output, 1 bit, one-cycle pulse confirming a successful save.
REQ-013 The block SHALL have port busy, output, 1 bit, high while a program change is being transmitted.

Function
REQ-014 The block SHALL hold a last_prog register (7 bits) plus have_prog flag, loaded/set on every cycle with prog_valid=1.
REQ-015 The block SHALL hold three 7-bit slot registers (slots 1..3) each with a slot_valid flag.
REQ-016 An event SHALL be accepted only when btn_index!=0, btn_index differs from its value in the previous cycle, and the FSM is IDLE; all other events are dropped, not queued.
REQ-017 Save event (save_mode=1): if have_prog or prog_valid is 1 in the same cycle, slot[btn_index] SHALL load the program (prog_num when prog_valid=1 that cycle, else last_prog), set slot_valid, set active_slot=btn_index, and pulse saved the next cycle; otherwise nothing changes and saved stays 0.
REQ-018 A save SHALL never transmit bytes and never leave IDLE.
REQ-019 Recall event (save_mode=0) with slot_valid[btn_index]=1 SHALL set active_slot=btn_index and move the FSM IDLE->SEND_STATUS; recall of an invalid slot SHALL be ignored.
REQ-020 FSM states SHALL be IDLE, SEND_STATUS, SEND_DATA; SEND_STATUS->SEND_DATA and SEND_DATA->IDLE each on a cycle with tx_valid=1 and tx_ready=1, otherwise hold.
REQ-021 In SEND_STATUS tx_data SHALL be {4'hC, MIDI_CHANNEL}; in SEND_DATA tx_data SHALL be {1'b0, slot value latched at acceptance}.
REQ-022 tx_valid SHALL be 1 exactly in SEND_STATUS and SEND_DATA; tx_data SHALL be stable while tx_valid=1 and tx_ready=0.
REQ-023 Latency: event accepted at edge N -> tx_valid=1 with status byte from edge N+1; with tx_ready tied high both bytes complete in 2 cycles and busy drops at edge N+3.
REQ-024 busy SHALL equal (state != IDLE).
REQ-025 prog_valid during a transmission SHALL update last_prog only; the byte in flight is unaffected.
REQ-026 A save to the slot currently being transmitted is impossible (events dropped while busy) and SHALL not alter tx_data.

Reset
REQ-027 While rst=1, immediately and regardless of clk: state=IDLE, tx_valid=0, tx_data=0, busy=0, saved=0, active_slot=0, have_prog=0, all slot_valid=0, slot and last_prog registers=0.
REQ-028 Reset asserted mid-transmission SHALL abort it; no byte is resumed after release.
REQ-029 The previous-btn_index register SHALL reset to 0, so a nonzero btn_index held across reset release is accepted once.

Verification
REQ-030 Save with nothing received: btn_index=2, save_mode=1 after reset -> saved stays 0, active_slot=0, no tx_valid.
REQ-031 Save then recall: prog_valid with prog_num=0x15, save slot 1, recall slot 1, tx_ready=1, MIDI_CHANNEL=3 -> saved pulse, then bytes 0xC3, 0x15, active_slot=1, busy high 2 cycles.
REQ-032 Backpressure: recall with tx_ready=0 for 5 cycles -> tx_valid=1, tx_data=0xC0 stable 5 cycles, then 0x15 after ready.
REQ-033 Events while busy and held index: btn_index=3 during transmission, and btn_index=1 held 4 cycles in IDLE -> first dropped, second transmits exactly once.
REQ-034 Simultaneous prog_valid (0x42) and save to slot 3 -> slot 3 stores 0x42; later recall sends 0xC0, 0x42.
REQ-035 rst pulsed after status byte accepted -> tx_valid=0 at once, no data byte afterwards, recall of slot 1 ignored (slot_valid cleared).

Source files
------------

// File: rtl/preset_sender.sv
// preset_sender
//   Footswitch preset controller. Remembers the last MIDI program number seen
//   on MIDI in, lets the player save it into one of three slots and recall a
//   slot. A recall sends a two-byte Program Change to the MIDI UART.
//
// Ports
//   clk          : single clock, rising edge
//   rst          : asynchronous active-high reset
//   btn_index    : footswitch event code, 0 = none, 1..3 = slot
//   save_mode    : 1 = save event, 0 = recall event
//   prog_valid   : one-cycle strobe, prog_num holds a received program
//   prog_num     : received program number
//   tx_data      : byte offered to the UART transmitter
//   tx_valid     : tx_data is valid
//   tx_ready     : transmitter takes tx_data this cycle
//   active_slot  : last saved or recalled slot (0 = none)
//   saved        : one-cycle pulse after a successful save
//   busy         : a Program Change is in flight
//
// state       | meaning
// ------------+---------------------------------------------
// IDLE        | waiting for a footswitch event
// SEND_STATUS | offering status byte 0xC<channel>
// SEND_DATA   | offering data byte {0, recalled program}

module preset_sender #(
  parameter logic [3:0] MIDI_CHANNEL = 4'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] btn_index,
  input  logic       save_mode,
  input  logic       prog_valid,
  input  logic [6:0] prog_num,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [1:0] active_slot,
  output logic       saved,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    SEND_STATUS = 2'd1,
    SEND_DATA   = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;

  logic [6:0] last_prog;
  logic       have_prog;
  logic [6:0] slot_prog [1:3];
  logic [3:1] slot_valid;
  logic [1:0] btn_prev;
  logic [6:0] tx_prog;

  logic       btn_event;
  logic       save_ok;
  logic       recall_ok;
  logic       tx_fire;
  logic [6:0] save_value;
  logic [6:0] sel_prog;
  logic       sel_valid;

  // Edge-detect the event code so a held footswitch fires only once. Events
  // outside IDLE are dropped, which also rules out overwriting the slot
  // whose value is currently being transmitted.
  assign btn_event  = (btn_index != 2'd0) && (btn_index != btn_prev) && (state == IDLE);
  assign save_value = prog_valid ? prog_num : last_prog;
  assign save_ok    = btn_event && save_mode && (have_prog || prog_valid);
  assign recall_ok  = btn_event && !save_mode && sel_valid;
  assign tx_fire    = tx_valid && tx_ready;

  always_comb begin
    sel_prog  = 7'd0;
    sel_valid = 1'b0;
    case (btn_index)
      2'd1: begin
        sel_prog  = slot_prog[1];
        sel_valid = slot_valid[1];
      end
      2'd2: begin
        sel_prog  = slot_prog[2];
        sel_valid = slot_valid[2];
      end
      2'd3: begin
        sel_prog  = slot_prog[3];
        sel_valid = slot_valid[3];
      end
      default: begin
        sel_prog  = 7'd0;
        sel_valid = 1'b0;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (recall_ok) begin
          state_nxt = SEND_STATUS;
        end
      end
      SEND_STATUS: begin
        if (tx_fire) begin
          state_nxt = SEND_DATA;
        end
      end
      SEND_DATA: begin
        if (tx_fire) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state only, so tx_data cannot move while a byte is
  // waiting for tx_ready, and reset clears them without a clock.
  always_comb begin
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    busy     = 1'b0;
    case (state)
      SEND_STATUS: begin
        tx_valid = 1'b1;
        tx_data  = {4'hC, MIDI_CHANNEL};
        busy     = 1'b1;
      end
      SEND_DATA: begin
        tx_valid = 1'b1;
        tx_data  = {1'b0, tx_prog};
        busy     = 1'b1;
      end
      default: begin
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        busy     = 1'b0;
      end
    endcase
  end

  // Received program tracking and footswitch edge history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_prog <= 7'd0;
      have_prog <= 1'b0;
      btn_prev  <= 2'd0;
    end else begin
      btn_prev <= btn_index;
      if (prog_valid) begin
        last_prog <= prog_num;
        have_prog <= 1'b1;
      end
    end
  end

  // Slot storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i <= 3; i++) begin
        slot_prog[i] <= 7'd0;
      end
      slot_valid <= 3'b000;
    end else if (save_ok) begin
      for (int i = 1; i <= 3; i++) begin
        if (btn_index == i[1:0]) begin
          slot_prog[i]  <= save_value;
          slot_valid[i] <= 1'b1;
        end
      end
    end
  end

  // Program captured at recall time; later saves or received programs must
  // not change the byte that is in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_prog     <= 7'd0;
      active_slot <= 2'd0;
      saved       <= 1'b0;
    end else begin
      saved <= save_ok;
      if (save_ok || recall_ok) begin
        active_slot <= btn_index;
      end
      if (recall_ok) begin
        tx_prog <= sel_prog;
      end
    end
  end

endmodule

// File: tb/tb_preset_sender.sv
module tb_preset_sender;

  logic       clk;
  logic       rst;
  logic [1:0] btn_index;
  logic       save_mode;
  logic       prog_valid;
  logic [6:0] prog_num;
  logic       tx_ready;

  logic [7:0] tx_data0,  tx_data3;
  logic       tx_valid0, tx_valid3;
  logic [1:0] active_slot0, active_slot3;
  logic       saved0, saved3;
  logic       busy0, busy3;

  int n_tests;
  int n_fail;

  preset_sender #(.MIDI_CHANNEL(4'd0)) dut0 (
    .clk(clk), .rst(rst), .btn_index(btn_index), .save_mode(save_mode),
    .prog_valid(prog_valid), .prog_num(prog_num), .tx_data(tx_data0),
    .tx_valid(tx_valid0), .tx_ready(tx_ready), .active_slot(active_slot0),
    .saved(saved0), .busy(busy0)
  );

  preset_sender #(.MIDI_CHANNEL(4'd3)) dut3 (
    .clk(clk), .rst(rst), .btn_index(btn_index), .save_mode(save_mode),
    .prog_valid(prog_valid), .prog_num(prog_num), .tx_data(tx_data3),
    .tx_valid(tx_valid3), .tx_ready(tx_ready), .active_slot(active_slot3),
    .saved(saved3), .busy(busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] btn;
    logic       sm;
    logic       pv;
    logic [6:0] pn;
    logic       rdy;
    logic       tv;
    logic [7:0] td;
    logic       bsy;
    logic       sv;
    logic [1:0] act;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [1:0] btn, input logic sm, input logic pv,
                              input logic [6:0] pn, input logic rdy, input logic tv,
                              input logic [7:0] td, input logic bsy, input logic sv,
                              input logic [1:0] act);
    vec_t v;
    v.btn = btn; v.sm = sm; v.pv = pv; v.pn = pn; v.rdy = rdy;
    v.tv = tv; v.td = td; v.bsy = bsy; v.sv = sv; v.act = act;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic tv, input logic [7:0] td,
                           input logic bsy, input logic sv, input logic [1:0] act);
    logic [7:0] td3;
    td3 = (tv && td[7:4] == 4'hC) ? 8'hC3 : td;
    check({tag, ".tx_valid"}, 32'(tx_valid0), 32'(tv));
    check({tag, ".tx_data"}, 32'(tx_data0), 32'(td));
    check({tag, ".busy"}, 32'(busy0), 32'(bsy));
    check({tag, ".saved"}, 32'(saved0), 32'(sv));
    check({tag, ".active_slot"}, 32'(active_slot0), 32'(act));
    check({tag, ".ch3_tx_valid"}, 32'(tx_valid3), 32'(tv));
    check({tag, ".ch3_tx_data"}, 32'(tx_data3), 32'(td3));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] btn, input logic sm, input logic pv,
                       input logic [6:0] pn, input logic rdy);
    btn_index = btn; save_mode = sm; prog_valid = pv; prog_num = pn; tx_ready = rdy;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    drive(2'd0, 1'b0, 1'b0, 7'h00, 1'b1);

    // Inputs are driven 1 time unit after a rising edge; each row's expected
    // outputs are those seen just after the next rising edge.
    //   btn  sm  pv  pn     rdy  tv   td     bsy  sv   act
    // save with nothing received
    add(2'd2, 1, 0, 7'h00, 1,   0, 8'h00,  0,   0,   2'd0);
    add(2'd0, 0, 0, 7'h00, 1,   0, 8'h00,  0,   0,   2'd0);
    // receive 0x15, save slot 1, recall slot 1
    add(2'd0, 0, 1, 7'h15, 1,   0, 8'h00,  0,   0,   2'd0);
    add(2'd1, 1, 0, 7'h00, 1,   0, 8'h00,  0,   1,   2'd1);
    add(2'd0, 0, 0, 7'h00, 1,   0, 8'h00,  0,   0,   2'd1);
    add(2'd1, 0, 0, 7'h00, 1,   1, 8'hC0,  1,   0,   2'd1);
    add(2'd0, 0, 0, 7'h00, 1,   1, 8'h15,  1,   0,   2'd1);
    add(2'd0, 0, 0, 7'h00, 1,   0, 8'h00,  0,   0,   2'd1);
    // backpressure: status held 5 cycles
    add(2'd1, 0, 0, 7'h00, 0,   1, 8'hC0,  1,   0,   2'd1);
    add(2'd1, 0, 0, 7'h00, 0,   1, 8'hC0,  1,   0,   2'd1);
    add(2'd1, 0, 0, 7'h00, 0,   1, 8'hC0,  1,   0,   2'd1);
    add(2'd1, 0, 0, 7'h00, 0,   1, 8'hC0,  1,   0,   2'd1);
    add(2'd1, 0, 0, 7'h00, 0,   1, 8'hC0,  1,   0,   2'd1);
    add(2'd1, 0, 0, 7'h00, 1,   1, 8'h15,  1,   0,   2'd1);
    add(2'd1, 0, 0, 7'h00, 0,   1, 8'h15,  1,   0,   2'd1);
    add(2'd1, 0, 0, 7'h00, 1,   0, 8'h00,  0,   0,   2'd1);
    // simultaneous receive 0x42 and save slot 3, then recall
    add(2'd0, 0, 0, 7'h00, 1,   0, 8'h00,  0,   0,   2'd1);
    add(2'd3, 1, 1, 7'h42, 1,   0, 8'h00,  0,   1,   2'd3);
    add(2'd0, 0, 0, 7'h00, 1,   0, 8'h00,  0,   0,   2'd3);
    add(2'd3, 0, 0, 7'h00, 1,   1, 8'hC0,  1,   0,   2'd3);
    add(2'd0, 0, 1, 7'h7F, 1,   1, 8'h42,  1,   0,   2'd3);
    add(2'd0, 0, 0, 7'h00, 1,   0, 8'h00,  0,   0,   2'd3);
    // event while busy dropped; held index fires once
    add(2'd1, 0, 0, 7'h00, 1,   1, 8'hC0,  1,   0,   2'd1);
    add(2'd3, 0, 0, 7'h00, 1,   1, 8'h15,  1,   0,   2'd1);
    add(2'd3, 0, 0, 7'h00, 1,   0, 8'h00,  0,   0,   2'd1);
    add(2'd0, 0, 0, 7'h00, 1,   0, 8'h00,  0,   0,   2'd1);
    add(2'd1, 0, 0, 7'h00, 1,   1, 8'hC0,  1,   0,   2'd1);
    add(2'd1, 0, 0, 7'h00, 1,   1, 8'h15,  1,   0,   2'd1);
    add(2'd1, 0, 0, 7'h00, 1,   0, 8'h00,  0,   0,   2'd1);
    add(2'd1, 0, 0, 7'h00, 1,   0, 8'h00,  0,   0,   2'd1);
    add(2'd0, 0, 0, 7'h00, 1,   0, 8'h00,  0,   0,   2'd1);
    // last_prog picked up 0x7F during the earlier transmission
    add(2'd2, 1, 0, 7'h00, 1,   0, 8'h00,  0,   1,   2'd2);
    add(2'd0, 0, 0, 7'h00, 1,   0, 8'h00,  0,   0,   2'd2);
    add(2'd2, 0, 0, 7'h00, 1,   1, 8'hC0,  1,   0,   2'd2);
    add(2'd0, 0, 0, 7'h00, 1,   1, 8'h7F,  1,   0,   2'd2);
    add(2'd0, 0, 0, 7'h00, 1,   0, 8'h00,  0,   0,   2'd2);

    // reset state
    #12;
    check_all("reset", 1'b0, 8'h00, 1'b0, 1'b0, 2'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].btn, vecs[i].sm, vecs[i].pv, vecs[i].pn, vecs[i].rdy);
      step();
      check_all($sformatf("vec%0d", i), vecs[i].tv, vecs[i].td, vecs[i].bsy,
                vecs[i].sv, vecs[i].act);
    end

    // reset after status byte accepted aborts the data byte
    drive(2'd1, 1'b0, 1'b0, 7'h00, 1'b1);
    step();
    check_all("abort.status", 1'b1, 8'hC0, 1'b1, 1'b0, 2'd1);
    step();
    check_all("abort.data", 1'b1, 8'h15, 1'b1, 1'b0, 2'd1);
    #2 rst = 1'b1;
    #1;
    check_all("abort.async", 1'b0, 8'h00, 1'b0, 1'b0, 2'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check_all($sformatf("abort.after%0d", k), 1'b0, 8'h00, 1'b0, 1'b0, 2'd0);
      drive(2'd0, 1'b0, 1'b0, 7'h00, 1'b1);
    end

    // index held across reset release is accepted once
    step();
    rst = 1'b1;
    drive(2'd2, 1'b1, 1'b1, 7'h05, 1'b1);
    @(posedge clk);
    #1 rst = 1'b0;
    step();
    check_all("held.save", 1'b0, 8'h00, 1'b0, 1'b1, 2'd2);
    prog_valid = 1'b0;
    step();
    check_all("held.once1", 1'b0, 8'h00, 1'b0, 1'b0, 2'd2);
    step();
    check_all("held.once2", 1'b0, 8'h00, 1'b0, 1'b0, 2'd2);
    drive(2'd0, 1'b0, 1'b0, 7'h00, 1'b1);
    step();
    drive(2'd2, 1'b0, 1'b0, 7'h00, 1'b1);
    step();
    check_all("held.rcl_status", 1'b1, 8'hC0, 1'b1, 1'b0, 2'd2);
    drive(2'd0, 1'b0, 1'b0, 7'h00, 1'b1);
    step();
    check_all("held.rcl_data", 1'b1, 8'h05, 1'b1, 1'b0, 2'd2);
    step();
    check_all("held.rcl_idle", 1'b0, 8'h00, 1'b0, 1'b0, 2'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
